// File: rtl/inst_loader_if.sv
// Bundles the host control, the byte stream and the instruction-memory write port
// that surround the instruction loader.
interface inst_loader_if;
  logic        start;
  logic [10:0] word_count;
  logic        abort;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;

  modport master (
    output start, word_count, abort, byte_valid, byte_data,
    input  byte_ready, we, waddr, wdata, busy, done, err, cpu_hold
  );

  modport slave (
    input  start, word_count, abort, byte_valid, byte_data,
    output byte_ready, we, waddr, wdata, busy, done, err, cpu_hold
  );
endinterface

// File: rtl/inst_loader.sv
// Instruction loader: collects a byte stream into big-endian 32-bit words and
// writes them to consecutive word addresses of instruction memory, holding the
// core while a load is in progress.
module inst_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input logic          clk,
  input logic          rst,
  inst_loader_if.slave bus
);

  // word_count is 11 bits, so any MAX_WORDS above 2047 accepts every nonzero count.
  localparam logic [11:0] MAX_LIMIT = (MAX_WORDS > 2047) ? 12'd2047 : 12'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t      state, state_n;
  logic [10:0] count, count_n;
  logic [10:0] word_idx, word_idx_n;
  logic [1:0]  byte_idx, byte_idx_n;
  logic [23:0] partial, partial_n;
  logic [31:0] waddr_n, wdata_n;
  logic        err_n;
  logic        start_ok;

  assign start_ok = (bus.word_count != 11'd0) && ({1'b0, bus.word_count} <= MAX_LIMIT);

  // Next-state and datapath decisions; every output is registered from these values.
  always_comb begin
    state_n    = state;
    count_n    = count;
    word_idx_n = word_idx;
    byte_idx_n = byte_idx;
    partial_n  = partial;
    waddr_n    = bus.waddr;
    wdata_n    = bus.wdata;
    err_n      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          if (start_ok) begin
            state_n    = COLLECT;
            count_n    = bus.word_count;
            word_idx_n = 11'd0;
            byte_idx_n = 2'd0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (bus.abort) begin
          state_n    = IDLE;
          byte_idx_n = 2'd0;
        end else if (bus.byte_valid) begin
          partial_n  = {partial[15:0], bus.byte_data};
          byte_idx_n = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            state_n = WRITE;
            waddr_n = BASE_ADDR + {19'd0, word_idx, 2'b00};
            wdata_n = {partial, bus.byte_data};
          end
        end
      end
      WRITE: begin
        byte_idx_n = 2'd0;
        if (bus.abort) begin
          state_n = IDLE;
        end else if (word_idx == count - 11'd1) begin
          state_n = DONE;
        end else begin
          state_n    = COLLECT;
          word_idx_n = word_idx + 11'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      count          <= 11'd0;
      word_idx       <= 11'd0;
      byte_idx       <= 2'd0;
      partial        <= 24'd0;
      bus.byte_ready <= 1'b0;
      bus.we         <= 1'b0;
      bus.waddr      <= BASE_ADDR;
      bus.wdata      <= 32'd0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
      bus.cpu_hold   <= 1'b0;
    end else begin
      state          <= state_n;
      count          <= count_n;
      word_idx       <= word_idx_n;
      byte_idx       <= byte_idx_n;
      partial        <= partial_n;
      bus.byte_ready <= (state_n == COLLECT);
      bus.we         <= (state_n == WRITE);
      bus.waddr      <= waddr_n;
      bus.wdata      <= wdata_n;
      bus.busy       <= (state_n == COLLECT) || (state_n == WRITE);
      bus.done       <= (state_n == DONE);
      bus.err        <= err_n;
      bus.cpu_hold   <= (state_n == COLLECT) || (state_n == WRITE);
    end
  end

endmodule
